// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp sequencer.
//   pwm_state_e      : sequencer FSM state (IDLE, RUN, RAMP)
//   PWM_MIN_PERIOD   : smallest period accepted; shorter requests are raised to it
//   pwm_step_toward  : move a duty value toward a target by a step, stopping on the target
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RAMP = 2'd2
  } pwm_state_e;

  localparam int unsigned PWM_MIN_PERIOD = 2;

  // Working width of the step helper. Callers zero-extend their CNT_W operands
  // into it and truncate the result back; CNT_W must not exceed this.
  localparam int unsigned PWM_FN_W = 32;

  // Step 0 means jump straight to the target. Otherwise move by `step` and
  // saturate at the target. The upward sum is one bit wider so it cannot wrap.
  function automatic logic [PWM_FN_W-1:0] pwm_step_toward(
    input logic [PWM_FN_W-1:0] cur,
    input logic [PWM_FN_W-1:0] tgt,
    input logic [PWM_FN_W-1:0] step
  );
    logic [PWM_FN_W:0]   sum;
    logic [PWM_FN_W-1:0] res;
    sum = {1'b0, cur} + {1'b0, step};
    if (step == '0) begin
      res = tgt;
    end else if (cur < tgt) begin
      res = (sum >= {1'b0, tgt}) ? tgt : sum[PWM_FN_W-1:0];
    end else begin
      // cur >= tgt here, so cur - tgt cannot underflow.
      res = ((cur - tgt) <= step) ? tgt : (cur - step);
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_period_counter.sv
// Period counter for the PWM sequencer.
//   clk, reset : clock, asynchronous active-low reset
//   clear_i    : hold the count at 0 (channel going or staying idle)
//   run_i      : channel was running in the current cycle
//   period_i   : active period in cycles (>= 2)
//   count_o    : position inside the current period, 0..period_i-1
//   last_o     : current cycle is the last of the period (the boundary)
//   first_o    : registered, high in the first cycle of every period
module pwm_period_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] period_i,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o,
  output logic             first_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             first_q, first_d;
  logic             wrap;

  assign last_o = run_i && (cnt_q == (period_i - CNT_W'(1)));
  // A new period starts either on the boundary or on the first running cycle.
  assign wrap   = !run_i || last_o;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    first_d = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wrap) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  assign count_o = cnt_q;
  assign first_o = first_q;

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Single-channel PWM generator with runtime period/duty control and soft ramping.
//   clk, reset    : clock, asynchronous active-low reset
//   enable        : run request; 0 idles the channel at once
//   cfg_valid/cfg_ready, cfg_period/cfg_duty/cfg_step : configuration handshake
//   pwm           : registered PWM output
//   period_start  : registered pulse in the first cycle of every period
//   duty_cur      : duty being generated in the current period
//   ramping       : duty_cur has not yet reached the active target
//   dbg_state     : FSM state for observation
//
// Handshake: a transfer happens on a rising edge where cfg_valid && cfg_ready.
// cfg_ready depends only on the FSM state (high in IDLE and RUN), never on
// cfg_valid. The master holds its data stable while cfg_valid is high.
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned DEFAULT_PERIOD = 100,
  parameter int unsigned DEFAULT_DUTY   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [CNT_W-1:0] cfg_step,
  output logic             pwm,
  output logic             period_start,
  output logic [CNT_W-1:0] duty_cur,
  output logic             ramping,
  output pwm_state_e       dbg_state
);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d, tgt_q, tgt_d, step_q, step_d;
  logic [CNT_W-1:0] shd_period_q, shd_period_d, shd_duty_q, shd_duty_d;
  logic [CNT_W-1:0] shd_step_q, shd_step_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;

  logic [CNT_W-1:0] cnt, san_period, san_duty, cur_dc;
  logic             cnt_last, cnt_first, idle, xfer, boundary;

  assign idle      = (state_q == ST_IDLE);
  assign cfg_ready = (state_q != ST_RAMP);
  assign xfer      = cfg_valid && cfg_ready;
  // Entering RUN/RAMP from IDLE counts as a boundary: the first period is
  // built from whatever settings are active at that moment.
  assign boundary  = enable && (idle || cnt_last);

  assign san_period = (cfg_period < CNT_W'(PWM_MIN_PERIOD)) ? CNT_W'(PWM_MIN_PERIOD) : cfg_period;
  assign san_duty   = (cfg_duty > san_period) ? san_period : cfg_duty;

  pwm_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (!enable),
    .run_i    (!idle),
    .period_i (period_q),
    .count_o  (cnt),
    .last_o   (cnt_last),
    .first_o  (cnt_first)
  );

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    tgt_d        = tgt_q;
    step_d       = step_q;
    shd_period_d = shd_period_q;
    shd_duty_d   = shd_duty_q;
    shd_step_d   = shd_step_q;
    pend_d       = pend_q;
    duty_d       = duty_q;
    pwm_d        = 1'b0;
    cur_dc       = '0;

    // While idle nothing is being generated, so settings land directly.
    if (xfer && idle) begin
      period_d = san_period;
      tgt_d    = san_duty;
      step_d   = cfg_step;
      pend_d   = 1'b0;
    end

    if (boundary) begin
      if (pend_d) begin
        period_d = shd_period_q;
        tgt_d    = shd_duty_q;
        step_d   = shd_step_q;
        pend_d   = 1'b0;
      end
      // Clamp to a shrinking period before stepping toward the target.
      cur_dc = idle ? '0 : duty_q;
      if (cur_dc > period_d) cur_dc = period_d;
      duty_d  = CNT_W'(pwm_step_toward(PWM_FN_W'(cur_dc), PWM_FN_W'(tgt_d), PWM_FN_W'(step_d)));
      state_d = (duty_d == tgt_d) ? ST_RUN : ST_RAMP;
      // Next count is 0: high whenever the new duty is non-zero.
      pwm_d   = (duty_d != '0);
    end else if (!idle) begin
      pwm_d = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) < (CNT_W+1)'(duty_q);
    end

    // Shadowed after the boundary update, so a transfer in the boundary
    // cycle waits for the following boundary.
    if (xfer && !idle) begin
      shd_period_d = san_period;
      shd_duty_d   = san_duty;
      shd_step_d   = cfg_step;
      pend_d       = 1'b1;
    end

    if (!enable) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      pwm_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      period_q     <= CNT_W'(DEFAULT_PERIOD);
      tgt_q        <= CNT_W'(DEFAULT_DUTY);
      step_q       <= '0;
      shd_period_q <= '0;
      shd_duty_q   <= '0;
      shd_step_q   <= '0;
      pend_q       <= 1'b0;
      duty_q       <= '0;
      pwm_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      tgt_q        <= tgt_d;
      step_q       <= step_d;
      shd_period_q <= shd_period_d;
      shd_duty_q   <= shd_duty_d;
      shd_step_q   <= shd_step_d;
      pend_q       <= pend_d;
      duty_q       <= duty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm          = pwm_q;
  assign period_start = cnt_first;
  assign duty_cur     = duty_q;
  assign ramping      = (state_q == ST_RAMP);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;
  localparam int W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic [W-1:0] cfg_step = '0;
  logic cfg_ready, pwm, period_start, ramping;
  logic [W-1:0] duty_cur;
  pwm_pkg::pwm_state_e dbg_state;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(.CNT_W(W), .DEFAULT_PERIOD(100), .DEFAULT_DUTY(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_step     (cfg_step),
    .pwm          (pwm),
    .period_start (period_start),
    .duty_cur     (duty_cur),
    .ramping      (ramping),
    .dbg_state    (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;
  bit cmp_en = 0;
  logic [W-1:0] exp_q[$];  // duty values expected at successive period starts

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one step per period-position) ----------------
  int m_period, m_tgt, m_step, m_duty, m_pos;
  int s_period, s_duty, s_step;
  bit m_on, m_pend, m_pwm, m_pstart;

  function automatic int approach(input int cur, input int tgt, input int step);
    if (step == 0 || cur == tgt) return tgt;
    if (cur < tgt) return (cur + step > tgt) ? tgt : cur + step;
    return (cur - step < tgt) ? tgt : cur - step;
  endfunction

  function automatic bit m_ready();
    return !(m_on && m_duty != m_tgt);
  endfunction

  task automatic model_reset();
    m_period = 100; m_tgt = 0; m_step = 0; m_duty = 0; m_pos = 0;
    s_period = 0; s_duty = 0; s_step = 0;
    m_on = 0; m_pend = 0; m_pwm = 0; m_pstart = 0;
  endtask

  task automatic model_step();
    bit xfer, bnd;
    int sp, sd, cur;
    xfer = cfg_valid && m_ready();
    sp = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
    sd = (int'(cfg_duty) > sp) ? sp : int'(cfg_duty);
    if (xfer && !m_on) begin
      m_period = sp; m_tgt = sd; m_step = int'(cfg_step); m_pend = 0;
    end
    bnd = enable && (!m_on || m_pos == m_period - 1);
    if (bnd) begin
      if (m_pend) begin
        m_period = s_period; m_tgt = s_duty; m_step = s_step; m_pend = 0;
      end
      cur = m_on ? m_duty : 0;
      if (cur > m_period) cur = m_period;
      m_duty = approach(cur, m_tgt, m_step);
      m_pos = 0;
    end else if (enable) begin
      m_pos++;
    end
    if (xfer && m_on) begin
      s_period = sp; s_duty = sd; s_step = int'(cfg_step); m_pend = 1;
    end
    if (!enable) begin
      m_on = 0; m_pos = 0; m_duty = 0;
    end else begin
      m_on = 1;
    end
    m_pstart = bnd;
    m_pwm = enable && (m_pos < m_duty);
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else model_step();
  end

  // Compare every cycle, half a period away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("pwm", 32'(pwm), 32'(m_pwm));
      chk("period_start", 32'(period_start), 32'(m_pstart));
      chk("duty_cur", 32'(duty_cur), 32'(m_duty));
      chk("ramping", 32'(ramping), 32'(m_on && m_duty != m_tgt));
      chk("cfg_ready", 32'(cfg_ready), 32'(m_ready()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_cfg(input int p, input int d, input int s);
    bit done;
    done = 0;
    @(posedge clk); #1;
    cfg_valid = 1'b1; cfg_period = W'(p); cfg_duty = W'(d); cfg_step = W'(s);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (cfg_ready === 1'b1) done = 1;
    end
    chk("cfg_accept", 32'(done), 32'd1);
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_pstart(output int waited);
    bit seen;
    seen = 0; waited = 0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      waited++;
      if (period_start === 1'b1) seen = 1;
    end
    chk("pstart_seen", 32'(seen), 32'd1);
  endtask

  task automatic count_window(input int n, output int highs, output int starts);
    highs = 0; starts = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      highs += int'(pwm);
      starts += int'(period_start);
    end
  endtask

  task automatic check_starts(input string name);
    int w;
    while (exp_q.size() > 0) begin
      wait_pstart(w);
      chk(name, 32'(duty_cur), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int highs, starts, w;
    model_reset();
    #2;
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_pstart", 32'(period_start), 32'd0);
    chk("rst_duty", 32'(duty_cur), 32'd0);
    chk("rst_ramping", 32'(ramping), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    cmp_en = 1;
    @(posedge clk); #1 reset = 1'b1;

    // Defaults: period 100, duty 0.
    @(posedge clk); #1 enable = 1'b1;
    count_window(300, highs, starts);
    chk("def_starts", 32'(starts), 32'd3);
    chk("def_highs", 32'(highs), 32'd0);
    chk("def_ramping", 32'(ramping), 32'd0);

    // Configure while idle; first period already uses it.
    @(posedge clk); #1 enable = 1'b0;
    do_cfg(10, 4, 0);
    enable = 1'b1;
    count_window(100, highs, starts);
    chk("idle_cfg_highs", 32'(highs), 32'd40);
    chk("idle_cfg_starts", 32'(starts), 32'd10);
    chk("idle_cfg_duty", 32'(duty_cur), 32'd4);

    // Ramp 0 -> 7 by 3.
    do_cfg(10, 0, 0);
    wait_pstart(w);
    wait_pstart(w);
    chk("duty_zero", 32'(duty_cur), 32'd0);
    do_cfg(10, 7, 3);
    wait_pstart(w);
    chk("ramp_d1", 32'(duty_cur), 32'd3);
    chk("ramp_busy", 32'(ramping), 32'd1);
    chk("ramp_not_ready", 32'(cfg_ready), 32'd0);
    exp_q.push_back(W'(6));
    exp_q.push_back(W'(7));
    check_starts("ramp_seq");
    chk("ramp_done", 32'(ramping), 32'd0);
    chk("ramp_ready", 32'(cfg_ready), 32'd1);

    // Sanitizing: period 1 -> 2, duty 5 -> 2 (constant high).
    do_cfg(1, 5, 0);
    wait_pstart(w);
    chk("clamp_duty", 32'(duty_cur), 32'd2);
    count_window(20, highs, starts);
    chk("clamp_highs", 32'(highs), 32'd20);
    chk("clamp_starts", 32'(starts), 32'd10);
    do_cfg(10, 12, 0);
    wait_pstart(w);
    wait_pstart(w);
    chk("clamp_duty10", 32'(duty_cur), 32'd10);

    // Transfer in the boundary cycle applies one period later.
    do_cfg(10, 2, 0);
    wait_pstart(w);
    wait_pstart(w);
    chk("bnd_pre", 32'(duty_cur), 32'd2);
    wait_pstart(w);
    repeat (9) @(posedge clk);
    #1;
    cfg_valid = 1'b1; cfg_period = W'(10); cfg_duty = W'(5); cfg_step = '0;
    @(negedge clk);
    chk("bnd_cycle_last", 32'(period_start), 32'd0);
    @(posedge clk); #1 cfg_valid = 1'b0;
    @(negedge clk);
    chk("bnd_start_old", 32'(period_start), 32'd1);
    chk("bnd_duty_old", 32'(duty_cur), 32'd2);
    wait_pstart(w);
    chk("bnd_duty_new", 32'(duty_cur), 32'd5);
    chk("bnd_period", 32'(w), 32'd10);

    // Two transfers in one period: last one wins.
    do_cfg(10, 8, 0);
    do_cfg(10, 3, 0);
    wait_pstart(w);
    chk("lastwins_duty", 32'(duty_cur), 32'd3);
    wait_pstart(w);
    chk("lastwins_period", 32'(w), 32'd10);

    // Drop enable mid-ramp, then re-enable from zero.
    do_cfg(10, 10, 1);
    exp_q.push_back(W'(4));
    exp_q.push_back(W'(5));
    check_starts("ramp_up");
    repeat (2) @(posedge clk);
    #1 enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_pwm", 32'(pwm), 32'd0);
    chk("drop_duty", 32'(duty_cur), 32'd0);
    chk("drop_ramping", 32'(ramping), 32'd0);
    @(posedge clk); #1 enable = 1'b1;
    wait_pstart(w);
    chk("reen_duty", 32'(duty_cur), 32'd1);

    // Asynchronous reset in the middle of a period start cycle.
    wait_pstart(w);
    chk("pre_rst_pwm", 32'(pwm), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_pwm", 32'(pwm), 32'd0);
    chk("arst_pstart", 32'(period_start), 32'd0);
    chk("arst_duty", 32'(duty_cur), 32'd0);
    chk("arst_ready", 32'(cfg_ready), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    do_cfg(10, 6, 2);
    enable = 1'b1;
    exp_q.push_back(W'(2));
    exp_q.push_back(W'(4));
    exp_q.push_back(W'(6));
    check_starts("post_rst_ramp");

    repeat (5) @(posedge clk);
    cmp_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_ramp_sequencer.md
# pwm_ramp_sequencer

Controller and sequencer for a single PWM output channel. Owns the period counter and duty comparison and accepts new period/duty targets over a valid/ready handshake. New settings apply only at period boundaries, so the waveform never glitches mid-period. Duty moves toward the target by a programmable step once per period, giving soft-start and soft-stop. The block sits between a register/config master and the pad-level `pwm` net and replaces free-running fixed-parameter PWM instances where runtime control is needed.

## Interface
Parameters:
- `CNT_W`, 16: width of counter, period, duty and step values.
- `DEFAULT_PERIOD`, 100: period (in clk cycles) after reset.
- `DEFAULT_DUTY`, 0: target duty (high cycles per period) after reset.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `enable`  in  1  run request; 0 forces idle.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted this cycle.
- `cfg_period`  in  CNT_W  requested period in cycles.
- `cfg_duty`  in  CNT_W  requested target duty in high cycles.
- `cfg_step`  in  CNT_W  duty change per period; 0 means jump to target.
- `pwm`  out  1  registered PWM output.
- `period_start`  out  1  one-cycle pulse on the first cycle of every period.
- `duty_cur`  out  CNT_W  duty currently being generated.
- `ramping`  out  1  high while `duty_cur` differs from the active target.

## Operation
- FSM states:
  - IDLE: `enable`=0; counter held at 0, `pwm`=0, `duty_cur` forced to 0.
  - RUN: `duty_cur` equals the target.
  - RAMP: `duty_cur` differs from the target.
- IDLE→RUN/RAMP when `enable`=1. Any state→IDLE on the cycle `enable`=0; the change is immediate, not deferred to a boundary.
- Counter counts 0..`period_act`−1 and wraps. The boundary is the cycle where counter = `period_act`−1.
- Handshake:
  - Transfer occurs when `cfg_valid` && `cfg_ready`.
  - `cfg_ready` = 1 in IDLE and RUN, and 0 in RAMP.
  - The accepted values go into shadow registers. A second transfer before the boundary overwrites the shadow (last write wins).
- Sanitizing at acceptance:
  - `cfg_period` < 2 → 2.
  - `cfg_duty` > sanitized period → that period (100%).
- At each boundary, in this order:
  - Pending shadow period and target become active.
  - `duty_cur` moves toward the target by `step_act`, saturating at the target with no overshoot. Step 0 sets `duty_cur` = target.
  - If the active period shrinks below `duty_cur`, `duty_cur` is clamped to the period first.
- A transfer accepted in the boundary cycle itself applies at the following boundary.
- In IDLE, a transfer applies immediately, so the first period after enable already uses it.
- Waveform: `pwm` is high on counter values 0..`duty_cur`−1. Duty 0 gives constant low; duty = period gives constant high.
- All arithmetic is unsigned CNT_W. Ramp add/subtract is computed at CNT_W+1 bits to avoid wrap-around.

## Timing
- Reset values:
  - `pwm`=0, `period_start`=0, `duty_cur`=0, `ramping`=0, `cfg_ready`=1.
  - FSM = IDLE; `period_act`=`DEFAULT_PERIOD`; target=`DEFAULT_DUTY`; `step_act`=0.
- `pwm` and `period_start` are registered and aligned: in the cycle `period_start`=1, `pwm` already reflects counter 0.
- `enable` rising at edge N: `period_start` and the first `pwm` high are visible after edge N+1.
- `enable` falling: `pwm`=0 after the next edge.
- `duty_cur` and `ramping` update in the first cycle of the new period, together with `period_start`.
- Reset asserted mid-period: all outputs take reset values asynchronously. Shadow contents are discarded.

## Structure
- Shared package `pwm_pkg` holds:
  - FSM state enum (IDLE, RUN, RAMP).
  - `PWM_MIN_PERIOD` = 2.
  - Saturating step function `pwm_step_toward(cur, tgt, step)`.
- One sub-module, `pwm_period_counter`. It takes the period, clears on idle, and outputs the count, a `last` flag and a `first` flag. The sequencer instantiates it once.

## Test plan
- Reset with defaults, `enable`=1 → `period_start` every 100 cycles, `pwm` constantly low (`DEFAULT_DUTY`=0), `ramping`=0.
- In IDLE, cfg period=10, duty=4, step=0; then enable → `pwm` high 4 cycles / low 6 cycles from the first period; `duty_cur`=4.
- RUN at period=10, duty=0; cfg duty=7, step=3 → `duty_cur` goes 3, 6, 7 over three consecutive periods. `cfg_ready`=0 and `ramping`=1 until 7 is reached.
- cfg period=1, duty=5 → period clamped to 2 and duty to 2, giving constant high. cfg duty=12 with period=10 → duty 10.
- Transfer in the boundary cycle, and two transfers in one period → only the last applies, one period later. No `pwm` glitch or short period appears.
- Drop `enable` mid-ramp, and separately assert `reset` mid-period → `pwm`=0 next cycle (immediately for reset). Re-enable then ramps up from `duty_cur`=0.
